// File: rtl/ppu_write_queue_pkg.sv
// Shared types and constants for the PPU write queue: the queued write record,
// control/status bit positions and a status-word packing helper.
package ppu_pkg;

  localparam int PPU_ADDR_W = 12;
  localparam int PPU_DATA_W = 32;
  localparam logic [PPU_ADDR_W-1:0] PPU_CTRL_ADDR = 12'hFFF;

  // Control register bits (written by the CPU at CTRL_ADDR)
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_IRQ_CLR = 1;
  localparam int CTRL_FLUSH   = 2;
  localparam int CTRL_OVF_CLR = 3;

  // Status word bits (read by the CPU at CTRL_ADDR)
  localparam int STAT_IRQ_EN    = 0;
  localparam int STAT_IRQ       = 1;
  localparam int STAT_VBLANK    = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef struct packed {
    logic [PPU_ADDR_W-1:0] addr;
    logic [PPU_DATA_W-1:0] data;
  } ppu_wr_t;

  function automatic logic [31:0] pack_status(input logic [7:0] count,
                                              input logic       ovf,
                                              input logic       vblank,
                                              input logic       irq,
                                              input logic       irq_en);
    logic [31:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: 8] = count;
    s[STAT_OVF]            = ovf;
    s[STAT_VBLANK]         = vblank;
    s[STAT_IRQ]            = irq;
    s[STAT_IRQ_EN]         = irq_en;
    return s;
  endfunction

endpackage

// File: rtl/ppu_write_queue_if.sv
// CPU slave bus plus the forwarded write port toward ppu_top.
// The queue sits on the slave side; the CPU/PPU environment is the master.
interface ppu_write_queue_if
  import ppu_pkg::*;
#(
  parameter int ADDR_W = PPU_ADDR_W,
  parameter int DATA_W = PPU_DATA_W
);

  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       readdata;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_address;
  logic [DATA_W-1:0] out_write_data;

  modport master (
    output chipselect, write, read, address, write_data, out_ready,
    input  readdata, out_valid, out_address, out_write_data
  );

  modport slave (
    input  chipselect, write, read, address, write_data, out_ready,
    output readdata, out_valid, out_address, out_write_data
  );

endinterface

// File: rtl/ppu_write_queue_fifo.sv
// Single-clock FIFO of ppu_wr_t with push, pop, flush and an occupancy count.
// A push into a full FIFO is taken only when a pop frees a slot the same cycle.
module ppu_sync_fifo
  import ppu_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  ppu_wr_t       wr_i,
  output ppu_wr_t       head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  ppu_wr_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // Flush beats everything; a pop frees room for a same-cycle push.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  // Next-state pointers and count
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the head is masked while empty so stale entries never leak out.
    if (do_push) mem_q[wr_ptr_q] <= wr_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ppu_write_queue.sv
// Defers CPU writes to PPU memory until vblank so video memories never change
// mid-frame. Also owns the vblank-start interrupt and a control/status register.
module ppu_write_queue
  import ppu_pkg::*;
#(
  parameter int               DEPTH     = 16,
  parameter int               ADDR_W    = PPU_ADDR_W,
  parameter int               DATA_W    = PPU_DATA_W,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = PPU_CTRL_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vblank,
  output logic               irq,
  ppu_write_queue_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          cpu_wr, ctrl_wr, push_req, stat_rd, pop, flush;
  logic          fifo_full, fifo_empty, vblank_rise;
  logic [CW-1:0] fifo_count;
  ppu_wr_t       wr_entry, head;

  logic          irq_q, irq_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic          vblank_q;
  logic [31:0]   readdata_q, readdata_d;

  // Address decode: the control register is never forwarded to the PPU.
  assign cpu_wr   = bus.chipselect && bus.write;
  assign ctrl_wr  = cpu_wr && (bus.address == CTRL_ADDR);
  assign push_req = cpu_wr && (bus.address != CTRL_ADDR);
  assign stat_rd  = bus.chipselect && bus.read && (bus.address == CTRL_ADDR);
  assign flush    = ctrl_wr && bus.write_data[CTRL_FLUSH];

  // Forwarding is gated by vblank combinationally so it stops the cycle vblank falls.
  assign bus.out_valid = vblank && !fifo_empty;
  assign pop           = bus.out_valid && bus.out_ready;

  assign wr_entry.addr = bus.address;
  assign wr_entry.data = bus.write_data;

  ppu_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .flush_i (flush),
    .wr_i    (wr_entry),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.out_address    = head.addr;
  assign bus.out_write_data = head.data;

  assign vblank_rise = vblank && !vblank_q;

  // Control, interrupt, overflow and status next-state
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_d      = irq_q;
    ovf_d      = ovf_q;
    readdata_d = '0;

    if (ctrl_wr) irq_en_d = bus.write_data[CTRL_IRQ_EN];

    // A vblank start wins over a clear landing in the same cycle.
    if (vblank_rise && irq_en_q)
      irq_d = 1'b1;
    else if (ctrl_wr && bus.write_data[CTRL_IRQ_CLR])
      irq_d = 1'b0;

    // A write into a full queue is dropped unless a beat drains this cycle.
    if (push_req && fifo_full && !pop)
      ovf_d = 1'b1;
    else if (ctrl_wr && bus.write_data[CTRL_OVF_CLR])
      ovf_d = 1'b0;

    if (stat_rd)
      readdata_d = pack_status(8'(fifo_count), ovf_q, vblank, irq_q, irq_en_q);
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      vblank_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      irq_q      <= irq_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      vblank_q   <= vblank;
      readdata_q <= readdata_d;
    end
  end

  assign irq          = irq_q;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_ppu_write_queue.sv
// Directed plus randomized bench for ppu_write_queue against a queue-based model.
module tb_ppu_write_queue;

  localparam int              DEPTH = 16;
  localparam int              AW    = 12;
  localparam int              DW    = 32;
  localparam logic [AW-1:0]   CTRL  = 12'hFFF;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic vblank;
  logic irq;

  ppu_write_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ppu_write_queue #(
    .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .CTRL_ADDR(CTRL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .vblank (vblank),
    .irq    (irq),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  wr_t         mq[$];
  bit          m_ovf, m_irq, m_irq_en, m_vbq;
  logic [31:0] m_rd;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
  endtask

  // Compare outputs with the model, advance the model, then cross one clock edge.
  task automatic step();
    wr_t h, e;
    bit  pop, cw, push, rs, rise;
    int  n;
    #1;
    n = mq.size();
    h = (n > 0) ? mq[0] : '0;
    check("out_valid",      bus.out_valid,      (vblank && n != 0));
    check("out_address",    bus.out_address,    h.a);
    check("out_write_data", bus.out_write_data, h.d);
    check("irq",            irq,                m_irq);
    check("readdata",       bus.readdata,       m_rd);

    if (!reset) begin
      mq.delete();
      m_ovf = 0; m_irq = 0; m_irq_en = 0; m_vbq = 0; m_rd = '0;
    end else begin
      pop  = vblank && (n != 0) && bus.out_ready;
      cw   = bus.chipselect && bus.write && (bus.address == CTRL);
      push = bus.chipselect && bus.write && (bus.address != CTRL);
      rs   = bus.chipselect && bus.read  && (bus.address == CTRL);
      rise = vblank && !m_vbq;
      m_rd = rs ? {16'h0, 8'(n), 4'h0, m_ovf, vblank, m_irq, m_irq_en} : 32'h0;
      if (rise && m_irq_en)             m_irq = 1;
      else if (cw && bus.write_data[1]) m_irq = 0;
      if (cw) m_irq_en = bus.write_data[0];
      if (cw && bus.write_data[3]) m_ovf = 0;
      if (cw && bus.write_data[2]) mq.delete();
      else if (pop) void'(mq.pop_front());
      if (push) begin
        if (n < DEPTH || pop) begin
          e.a = bus.address;
          e.d = bus.write_data;
          mq.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
      m_vbq = vblank;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.read       = 1'b0;
    bus.address    = a;
    bus.write_data = d;
    step();
    idle();
  endtask

  task automatic stat_rd();
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    bus.address    = CTRL;
    step();
    idle();
  endtask

  logic [DW-1:0] ovf_data [17];
  logic [AW-1:0] exp_a    [16];
  logic [DW-1:0] exp_d    [16];
  logic [31:0]   cd;

  initial begin
    idle();
    reset         = 1'b0;
    vblank        = 1'b0;
    bus.out_ready = 1'b0;
    m_ovf = 0; m_irq = 0; m_irq_en = 0; m_vbq = 0; m_rd = '0;

    // 1. Reset then idle
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    stat_rd();
    check("t1_status", bus.readdata, 32'h0);
    check("t1_irq", irq, 1'b0);

    // 2. Deferred drain
    bus.out_ready = 1'b1;
    cpu_wr(12'h010, 32'hAABBCCDD);
    cpu_wr(12'h200, 32'h11223344);
    step();
    check("t2_held", bus.out_valid, 1'b0);
    vblank = 1'b1;
    #1;
    check("t2_valid0", bus.out_valid, 1'b1);
    check("t2_addr0", bus.out_address, 12'h010);
    check("t2_data0", bus.out_write_data, 32'hAABBCCDD);
    step();
    check("t2_addr1", bus.out_address, 12'h200);
    check("t2_data1", bus.out_write_data, 32'h11223344);
    step();
    check("t2_empty", bus.out_valid, 1'b0);
    vblank = 1'b0;
    stat_rd();
    check("t2_count", bus.readdata[15:8], 8'd0);

    // 3. Overflow
    for (int i = 0; i < 17; i++) begin
      ovf_data[i] = $urandom;
      cpu_wr(12'h100 + 12'(i), ovf_data[i]);
    end
    stat_rd();
    check("t3_status_full_ovf", bus.readdata, 32'h0000_1008);
    cpu_wr(CTRL, 32'h8);
    stat_rd();
    check("t3_ovf_cleared", bus.readdata, 32'h0000_1000);

    // 4. Push and pop in the same cycle while full
    vblank = 1'b1;
    cpu_wr(12'h3AA, 32'hCAFEF00D);
    vblank = 1'b0;
    stat_rd();
    check("t4_status", bus.readdata, 32'h0000_1000);
    for (int i = 0; i < 15; i++) begin
      exp_a[i] = 12'h100 + 12'(i + 1);
      exp_d[i] = ovf_data[i + 1];
    end
    exp_a[15] = 12'h3AA;
    exp_d[15] = 32'hCAFEF00D;
    vblank = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("t4_drain_addr", bus.out_address, exp_a[i]);
      check("t4_drain_data", bus.out_write_data, exp_d[i]);
      step();
    end
    check("t4_drained", bus.out_valid, 1'b0);
    vblank = 1'b0;
    step();

    // 5. IRQ
    cpu_wr(CTRL, 32'h1);
    check("t5_irq_idle", irq, 1'b0);
    vblank = 1'b1;
    step();
    check("t5_irq_set", irq, 1'b1);
    cpu_wr(CTRL, 32'h3);
    check("t5_irq_clr", irq, 1'b0);
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    cpu_wr(CTRL, 32'h3);
    check("t5_set_wins", irq, 1'b1);
    cpu_wr(CTRL, 32'h2);
    check("t5_irq_clr2", irq, 1'b0);
    vblank = 1'b0;
    step();

    // 6. vblank drop, flush, reset mid-drain
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cpu_wr(12'h040 + 12'(i), $urandom);
    vblank = 1'b1;
    step();
    step();
    vblank = 1'b0;
    #1;
    check("t6_valid_drop", bus.out_valid, 1'b0);
    step();
    stat_rd();
    check("t6_count4", bus.readdata, 32'h0000_0400);
    cpu_wr(CTRL, 32'h4);
    stat_rd();
    check("t6_flushed", bus.readdata, 32'h0);
    for (int i = 0; i < 3; i++) cpu_wr(12'h080 + 12'(i), $urandom);
    vblank        = 1'b1;
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_addr", bus.out_address, 12'h0);
    check("t6_rst_data", bus.out_write_data, 32'h0);
    check("t6_rst_irq", irq, 1'b0);
    check("t6_rst_rd", bus.readdata, 32'h0);
    reset  = 1'b1;
    vblank = 1'b0;
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 15) == 0) vblank = ~vblank;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 199) != 0);
      cd = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) != 0) cd[2] = 1'b0;
      case ($urandom_range(0, 5))
        0, 1: begin
          bus.chipselect = 1'b1;
          bus.write      = 1'b1;
          bus.address    = 12'($urandom_range(0, 12'hFFE));
          bus.write_data = $urandom;
        end
        2: begin
          bus.chipselect = 1'b1;
          bus.write      = 1'b1;
          bus.address    = CTRL;
          bus.write_data = cd;
        end
        3: begin
          bus.chipselect = 1'b1;
          bus.read       = 1'b1;
          bus.address    = ($urandom_range(0, 3) != 0) ? CTRL : 12'h123;
        end
        4: begin
          bus.chipselect = 1'b1;
          bus.read       = 1'b1;
          bus.write      = 1'b1;
          bus.address    = CTRL;
          bus.write_data = cd;
        end
        default: ;
      endcase
      step();
    end
    idle();
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
